// File: rtl/issue_queue_if.sv
// issue_queue_if: rename/wakeup/EXE handshake bundle for issue_queue.
interface issue_queue_if;
    logic         alloc_valid;
    logic [169:0] alloc_entry;
    logic [63:0]  busy;
    logic         wake_valid;
    logic [5:0]   wake_reg;
    logic         exe_ready;
    logic         issue_valid;
    logic [169:0] issue_entry;
    logic         iq_halt;
    logic [4:0]   count;
    modport master (
        output alloc_valid, alloc_entry, busy, wake_valid, wake_reg, exe_ready,
        input  issue_valid, issue_entry, iq_halt, count
    );
    modport slave (
        input  alloc_valid, alloc_entry, busy, wake_valid, wake_reg, exe_ready,
        output issue_valid, issue_entry, iq_halt, count
    );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: age-ordered compacting issue queue with wakeup and oldest-ready select.
// Define ISSUE_BYPASS_EN to let an allocation capture a same-cycle wakeup of its sources.
module issue_queue #(
    parameter int DEPTH = 8
) (
    input logic CLK,
    input logic RESET,
    input logic FLUSH,
    issue_queue_if.slave iq
);
`ifdef ISSUE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    logic [DEPTH-1:0] vld_q, rdya_q, rdyb_q, vld_n, rdya_n, rdyb_n;
    logic [DEPTH:0]   vld_x, rdya_x, rdyb_x;
    logic [169:0]     ent_q [DEPTH];
    logic [169:0]     ent_n [DEPTH];
    logic [169:0]     ent_x [DEPTH+1];
    logic [4:0]       count_q, count_n;
    logic             issue_valid_q, do_issue, alloc_ok, new_rdya, new_rdyb;
    logic [169:0]     issue_entry_q, sel_entry;
    logic [5:0]       new_a, new_b;
    int               sel, base, k;
    // slot DEPTH is a permanently empty slot so the top of the array can shift down uniformly
    assign vld_x  = {1'b0, vld_q};
    assign rdya_x = {1'b0, rdya_q};
    assign rdyb_x = {1'b0, rdyb_q};
    always_comb begin
        ent_x[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) ent_x[i] = ent_q[i];
    end
    assign new_a    = iq.alloc_entry[5:0];
    assign new_b    = iq.alloc_entry[11:6];
    assign new_rdya = (new_a == 6'd0) || !iq.busy[new_a] || (BYPASS && iq.wake_valid && iq.wake_reg == new_a);
    assign new_rdyb = (new_b == 6'd0) || !iq.busy[new_b] || (BYPASS && iq.wake_valid && iq.wake_reg == new_b);
    always_comb begin
        sel = DEPTH;
        sel_entry = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && rdya_q[i] && rdyb_q[i]) begin
                sel = i;
                sel_entry = ent_q[i];
            end
        end
        do_issue = iq.exe_ready && sel < DEPTH;
        base = int'(count_q) - (do_issue ? 1 : 0);
        alloc_ok = iq.alloc_valid && base < DEPTH;
        count_n = 5'(base) + (alloc_ok ? 5'd1 : 5'd0);
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            k = (do_issue && i >= sel) ? i + 1 : i;
            vld_n[i]  = vld_x[k];
            ent_n[i]  = ent_x[k];
            rdya_n[i] = rdya_x[k] || (iq.wake_valid && iq.wake_reg == ent_x[k][5:0]);
            rdyb_n[i] = rdyb_x[k] || (iq.wake_valid && iq.wake_reg == ent_x[k][11:6]);
            if (alloc_ok && i == base) begin
                vld_n[i]  = 1'b1;
                ent_n[i]  = iq.alloc_entry;
                rdya_n[i] = new_rdya;
                rdyb_n[i] = new_rdyb;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_q         <= '0;
            rdya_q        <= '0;
            rdyb_q        <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
        end else if (FLUSH) begin
            vld_q         <= '0;
            rdya_q        <= '0;
            rdyb_q        <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            vld_q         <= vld_n;
            rdya_q        <= rdya_n;
            rdyb_q        <= rdyb_n;
            ent_q         <= ent_n;
            count_q       <= count_n;
            issue_valid_q <= do_issue;
            issue_entry_q <= do_issue ? sel_entry : issue_entry_q;
        end
    end
    assign iq.issue_valid = issue_valid_q;
    assign iq.issue_entry = issue_entry_q;
    assign iq.count       = count_q;
    // one spare slot absorbs the allocation already in flight from rename's output register
    assign iq.iq_halt     = (5'(DEPTH) - count_q) <= 5'd1;
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and randomized checks of issue_queue against a queue-based reference model.
module tb_issue_queue;
    localparam int DEPTH = 8;
`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic CLK = 1'b0;
    logic RESET, FLUSH;
    issue_queue_if iq();
    issue_queue #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .iq(iq.slave));
    always #5 CLK = ~CLK;
    typedef struct {
        logic [169:0] e;
        bit           ra;
        bit           rb;
    } slot_t;
    slot_t        mq[$];
    bit           exp_valid = 1'b0;
    logic [169:0] exp_entry = '0;
    bit           started = 1'b0;
    int           checks = 0;
    int           errors = 0;
    task automatic chk(input string name, input logic [169:0] act, input logic [169:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [169:0] mk(input logic [5:0] a, input logic [5:0] b, input logic [31:0] t);
        return {56'h0, t, t ^ 32'hdeadbeef, t + 32'd1, t[5:0], b, a};
    endfunction
    function automatic bit src_ready(input logic [5:0] s);
        return s == 6'd0 || !iq.busy[s] || (BYP && iq.wake_valid && iq.wake_reg == s);
    endfunction
    // Reference: oldest ready entry leaves, survivors see the wakeup, newcomer joins the tail.
    task automatic model_step();
        int s;
        slot_t n;
        if (RESET) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_entry = '0;
            return;
        end
        if (FLUSH) begin
            mq.delete();
            exp_valid = 1'b0;
            return;
        end
        s = -1;
        foreach (mq[i]) if (s < 0 && mq[i].ra && mq[i].rb) s = i;
        exp_valid = iq.exe_ready && s >= 0;
        if (exp_valid) begin
            exp_entry = mq[s].e;
            mq.delete(s);
        end
        foreach (mq[i]) begin
            if (iq.wake_valid && mq[i].e[5:0] == iq.wake_reg) mq[i].ra = 1'b1;
            if (iq.wake_valid && mq[i].e[11:6] == iq.wake_reg) mq[i].rb = 1'b1;
        end
        if (iq.alloc_valid && mq.size() < DEPTH) begin
            n.e  = iq.alloc_entry;
            n.ra = src_ready(iq.alloc_entry[5:0]);
            n.rb = src_ready(iq.alloc_entry[11:6]);
            mq.push_back(n);
        end
    endtask
    always @(negedge CLK) begin
        if (started) begin
            chk("count", 170'(iq.count), 170'(mq.size()));
            chk("issue_valid", 170'(iq.issue_valid), 170'(exp_valid));
            chk("issue_entry", iq.issue_entry, exp_entry);
            chk("iq_halt", 170'(iq.iq_halt), 170'((DEPTH - mq.size()) <= 1));
        end
    end
    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask
    task automatic idle();
        iq.alloc_valid = 1'b0;
        iq.wake_valid  = 1'b0;
        FLUSH = 1'b0;
        RESET = 1'b0;
    endtask
    task automatic alloc(input logic [169:0] e);
        idle();
        iq.alloc_valid = 1'b1;
        iq.alloc_entry = e;
    endtask
    initial begin
        idle();
        iq.alloc_entry = '0;
        iq.busy = '0;
        iq.wake_reg = '0;
        iq.exe_ready = 1'b0;
        RESET = 1'b1;
        cyc();
        started = 1'b1;
        chk("rst_count", 170'(iq.count), 170'(0));
        chk("rst_valid", 170'(iq.issue_valid), 170'(0));
        chk("rst_entry", iq.issue_entry, 170'(0));
        chk("rst_halt", 170'(iq.iq_halt), 170'(0));
        // single ready entry issues one edge after allocation
        iq.exe_ready = 1'b1;
        alloc(mk(6'd5, 6'd6, 32'd1));
        cyc();
        chk("t1_alloc_count", 170'(iq.count), 170'(1));
        chk("t1_alloc_valid", 170'(iq.issue_valid), 170'(0));
        idle();
        cyc();
        chk("t1_issue_valid", 170'(iq.issue_valid), 170'(1));
        chk("t1_issue_entry", iq.issue_entry, mk(6'd5, 6'd6, 32'd1));
        chk("t1_count", 170'(iq.count), 170'(0));
        // younger ready entry bypasses an older blocked one; wakeup releases the older
        iq.busy[10] = 1'b1;
        alloc(mk(6'd10, 6'd0, 32'd2));
        cyc();
        iq.busy = '0;
        alloc(mk(6'd5, 6'd6, 32'd3));
        cyc();
        idle();
        cyc();
        chk("t2_b_valid", 170'(iq.issue_valid), 170'(1));
        chk("t2_b_entry", iq.issue_entry, mk(6'd5, 6'd6, 32'd3));
        chk("t2_b_count", 170'(iq.count), 170'(1));
        iq.wake_valid = 1'b1;
        iq.wake_reg = 6'd10;
        cyc();
        chk("t2_wake_valid", 170'(iq.issue_valid), 170'(0));
        idle();
        cyc();
        chk("t2_a_valid", 170'(iq.issue_valid), 170'(1));
        chk("t2_a_entry", iq.issue_entry, mk(6'd10, 6'd0, 32'd2));
        chk("t2_a_count", 170'(iq.count), 170'(0));
        // fill with blocked entries; halt at DEPTH-1, overflow dropped
        iq.exe_ready = 1'b0;
        iq.busy[20] = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            alloc(mk(6'd20, 6'd0, 32'(100 + i)));
            cyc();
            if (i == DEPTH - 3) chk("t3_halt_low", 170'(iq.iq_halt), 170'(0));
            if (i == DEPTH - 2) chk("t3_halt_high", 170'(iq.iq_halt), 170'(1));
        end
        chk("t3_full_count", 170'(iq.count), 170'(DEPTH));
        idle();
        FLUSH = 1'b1;
        cyc();
        chk("t3_flush_count", 170'(iq.count), 170'(0));
        // flush discards the same-cycle alloc and issue
        iq.busy = '0;
        for (int i = 0; i < 4; i++) begin
            alloc(mk(6'd1, 6'd2, 32'(200 + i)));
            cyc();
        end
        chk("t4_pre_count", 170'(iq.count), 170'(4));
        alloc(mk(6'd1, 6'd2, 32'd250));
        iq.exe_ready = 1'b1;
        FLUSH = 1'b1;
        cyc();
        chk("t4_flush_count", 170'(iq.count), 170'(0));
        chk("t4_flush_valid", 170'(iq.issue_valid), 170'(0));
        idle();
        cyc();
        chk("t4_after_valid", 170'(iq.issue_valid), 170'(0));
        chk("t4_after_count", 170'(iq.count), 170'(0));
        // same-cycle wakeup at allocation
        iq.busy[12] = 1'b1;
        alloc(mk(6'd12, 6'd0, 32'd300));
        iq.wake_valid = 1'b1;
        iq.wake_reg = 6'd12;
        cyc();
        idle();
        iq.busy = '0;
        cyc();
        chk("t5_bypass_valid", 170'(iq.issue_valid), 170'(BYP));
`ifndef ISSUE_BYPASS_EN
        iq.wake_valid = 1'b1;
        iq.wake_reg = 6'd12;
        cyc();
        idle();
        cyc();
        chk("t5_late_valid", 170'(iq.issue_valid), 170'(1));
        chk("t5_late_entry", iq.issue_entry, mk(6'd12, 6'd0, 32'd300));
`endif
        // reset wipes entries including the one being selected
        iq.exe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc(mk(6'd3, 6'd4, 32'(400 + i)));
            cyc();
        end
        idle();
        iq.exe_ready = 1'b1;
        RESET = 1'b1;
        cyc();
        chk("t6_count", 170'(iq.count), 170'(0));
        chk("t6_valid", 170'(iq.issue_valid), 170'(0));
        chk("t6_entry", iq.issue_entry, 170'(0));
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            iq.alloc_valid = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH - 1 || $urandom_range(0, 7) == 0);
            iq.alloc_entry = mk(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), $urandom);
            iq.busy = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            iq.busy[0] = 1'b0;
            iq.wake_valid = 1'($urandom_range(0, 1));
            iq.wake_reg = 6'($urandom_range(0, 15));
            iq.exe_ready = $urandom_range(0, 3) != 0;
            FLUSH = $urandom_range(0, 99) == 0;
            RESET = $urandom_range(0, 299) == 0;
            cyc();
        end
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of queue slots (power of two, 4..16).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous reset, active-high.
REQ-004 FLUSH  input  1  synchronous squash of all queue contents.
REQ-005 alloc_valid  input  1  rename allocates one entry this cycle.
REQ-006 alloc_entry  input  170  renamed entry: [169:82] control, [81:50] instr, [49:18] pc, [17:12] dest phys, [11:6] src B phys, [5:0] src A phys.
REQ-007 busy  input  64  per-physical-register busy vector from rename.
REQ-008 wake_valid  input  1  EXE result broadcast valid.
REQ-009 wake_reg  input  6  physical register being written by EXE.
REQ-010 exe_ready  input  1  EXE accepts one issued entry this cycle.
REQ-011 issue_valid  output  1  registered one-cycle pulse: issue_entry valid.
REQ-012 issue_entry  output  170  issued entry, same layout as alloc_entry.
REQ-013 iq_halt  output  1  combinational: free slots <= 1; rename stops allocating.
REQ-014 count  output  5  registered number of occupied slots.

Function
REQ-015 Storage is age-ordered compacting array: slot 0 oldest, new entries written at slot count (after removal compaction).
REQ-016 Per slot: valid, entry, rdyA, rdyB.
REQ-017 On allocation, rdyX = (srcX == 0) | !busy[srcX]; with ISSUE_BYPASS_EN also set if wake_valid & wake_reg == srcX that cycle.
REQ-018 Every cycle, any valid slot with srcX == wake_reg and wake_valid sets rdyX; physical reg 0 never busy.
REQ-019 Select: lowest-index valid slot with rdyA & rdyB, evaluated on ready bits held at start of cycle.
REQ-020 If exe_ready and a selected slot exists: slot removed, slots above shift down one, issue_entry <= slot entry, issue_valid <= 1 next cycle; else issue_valid <= 0, issue_entry holds.
REQ-021 At most one allocation and one issue per cycle; simultaneous alloc + issue: count unchanged, new entry lands at count-1 after shift.
REQ-022 Alloc-to-issue minimum latency: alloc at edge N, issued at edge N+1 at earliest, issue_valid high after N+1.
REQ-023 alloc_valid while count == DEPTH and no issue that cycle: entry dropped, count unchanged (upstream error; iq_halt prevents it).
REQ-024 iq_halt = (DEPTH - count) <= 1, covering the one-cycle registered rename output.
REQ-025 FLUSH: next edge all valid cleared, count = 0, issue_valid = 0; alloc and issue that cycle discarded; FLUSH overrides wakeup.
REQ-026 Wakeup does not cause issue in the same cycle it arrives; earliest issue is next edge.

Reset
REQ-027 RESET high at rising edge: all valid/rdy bits 0, count 0, issue_valid 0, issue_entry 0; overrides FLUSH, alloc, wakeup.
REQ-028 RESET asserted mid-operation discards all entries including one being issued that cycle.

Configuration
REQ-029 Macro ISSUE_BYPASS_EN defined: allocation captures same-cycle wakeup (REQ-017), source ready without waiting for busy update.
REQ-030 ISSUE_BYPASS_EN undefined: allocation uses busy only; entry with same-cycle wakeup stays not-ready until rename's busy is cleared, or forever if busy already sampled -- rename must then provide cleared busy the following cycle (stale-busy risk accepted).

Verification
REQ-031 Alloc entry srcA=5,srcB=6, busy all 0, exe_ready=1 -> issue_valid pulse next edge, issue_entry equal, count back to 0.
REQ-032 Alloc A (srcA=10 busy), then B (ready), exe_ready=1 -> B issued first, A held; wake_reg=10 -> A issued one edge later.
REQ-033 Fill 7 of 8 slots with busy sources -> iq_halt=1 at count 7; 9th alloc with count 8 dropped, count stays 8.
REQ-034 Count=4, FLUSH with alloc_valid and exe_ready high -> next edge count 0, issue_valid 0, no entry issued.
REQ-035 With ISSUE_BYPASS_EN: alloc srcA=12 busy, wake_reg=12 same cycle -> issued next edge; without macro -> not issued until busy[12] low at a later allocation-independent wakeup.
REQ-036 RESET pulsed with count=3 and ready entry selected -> count 0, issue_valid 0, issue_entry 0.
